// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: digit count,
// blanked output levels, scan FSM encoding and the buffered frame record.
package seg_scan_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  en;
  } frame_t;
endpackage

// File: rtl/bcd_seg_decode.sv
// BCD to active-low {g..a} segment pattern for a common-anode display;
// codes 10-15 leave every segment dark.
module bcd_seg_decode (
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = 7'b1111111;
    case (bcd)
      4'd0: seg_n = 7'b1000000;
      4'd1: seg_n = 7'b1111001;
      4'd2: seg_n = 7'b0100100;
      4'd3: seg_n = 7'b0110000;
      4'd4: seg_n = 7'b0011001;
      4'd5: seg_n = 7'b0010010;
      4'd6: seg_n = 7'b0000010;
      4'd7: seg_n = 7'b1111000;
      4'd8: seg_n = 7'b0000000;
      4'd9: seg_n = 7'b0010000;
      default: seg_n = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit time-multiplexed display scanner with guard gaps between digits,
// leading-zero blanking and frame-synchronous double buffering of the data.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int SHOW_CYC = 99984,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_in,
  input  logic        lz_blank,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);
  localparam int MAXC = (SHOW_CYC > GUARD) ? SHOW_CYC : GUARD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic [0:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  frame_t        com_reg;
  frame_t        pend_reg;
  logic          pend_valid_reg;

  frame_t                  live;
  logic [3:0]              nibble;
  logic [6:0]              dec;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    visible;
  logic                    guard_end;
  logic                    show_end;
  logic                    boundary;

  assign live   = '{digits: digits, dp: dp_in, en: en_in};
  assign nibble = com_reg.digits[{idx_reg, 2'b00} +: 4];

  bcd_seg_decode u_dec (
    .bcd   (nibble),
    .seg_n (dec)
  );

  // upper_zero[i]: digit i and every more significant digit are zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    assign upper_zero[gi] = (com_reg.digits[31:4*gi] == '0);
  end

  assign visible   = com_reg.en[idx_reg] &&
                     !(lz_blank && (idx_reg != 3'd0) && upper_zero[idx_reg]);
  assign guard_end = (state_reg == ST_BLANK) && (cnt_reg == CW'(GUARD - 1));
  assign show_end  = (state_reg == ST_SHOW) && (cnt_reg == CW'(SHOW_CYC - 1));
  assign boundary  = show_end && (idx_reg == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_BLANK;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      an             <= AN_OFF;
      seg            <= SEG_OFF;
      frame_done     <= 1'b0;
      com_reg        <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      frame_done <= boundary;

      // Outputs are loaded on the edge that enters each state, so they never lag the FSM.
      if (guard_end) begin
        state_reg <= ST_SHOW;
        cnt_reg   <= '0;
        an        <= visible ? ~(8'b1 << idx_reg) : AN_OFF;
        seg       <= visible ? {~com_reg.dp[idx_reg], dec} : SEG_OFF;
      end else if (show_end) begin
        state_reg <= ST_BLANK;
        cnt_reg   <= '0;
        idx_reg   <= idx_reg + 3'd1;
        an        <= AN_OFF;
        seg       <= SEG_OFF;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      // A load landing exactly on the boundary bypasses the pending buffer.
      if (boundary) begin
        if (load) begin
          com_reg <= live;
        end else if (pend_valid_reg) begin
          com_reg <= pend_reg;
        end
        pend_valid_reg <= 1'b0;
      end else if (load) begin
        pend_reg       <= live;
        pend_valid_reg <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-arithmetic reference model checked every
// cycle, a table of display vectors, hand sequences and random loads.
module tb_seg_scan_ctrl;
  localparam int SC = 4;
  localparam int G  = 2;
  localparam int P  = SC + G;
  localparam int FR = 8 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  en_in = '0;
  logic        lz_blank = 1'b0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SHOW_CYC(SC), .GUARD(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .digits     (digits),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset, committed and pending frames.
  int          e;
  logic [31:0] m_dig, p_dig;
  logic [7:0]  m_dp, m_en, p_dp, p_en;
  bit          pv;
  logic [7:0]  x_an, x_seg;
  logic        x_fd;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        lz;
    int          slot;
    logic [7:0]  an;
    logic [7:0]  seg;
  } vec_t;
  vec_t tbl[11];

  function automatic logic [6:0] pat(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'd0: r = 7'h40;  4'd1: r = 7'h79;  4'd2: r = 7'h24;  4'd3: r = 7'h30;
      4'd4: r = 7'h19;  4'd5: r = 7'h12;  4'd6: r = 7'h02;  4'd7: r = 7'h78;
      4'd8: r = 7'h00;  4'd9: r = 7'h10;  default: r = 7'h7F;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, e);
    end
  endtask

  task automatic step();
    int slot, ph;
    logic [31:0] up;
    bit vis, bnd;
    @(posedge clk);
    if (rst) begin
      e = 0; m_dig = '0; m_dp = '0; m_en = '0; pv = 0;
      x_an = 8'hFF; x_seg = 8'hFF; x_fd = 1'b0;
    end else begin
      e++;
      bnd = (e % FR == 0);
      if (bnd) begin
        if (load) begin
          m_dig = digits; m_dp = dp_in; m_en = en_in;
        end else if (pv) begin
          m_dig = p_dig; m_dp = p_dp; m_en = p_en;
        end
        pv = 0;
      end else if (load) begin
        p_dig = digits; p_dp = dp_in; p_en = en_in; pv = 1;
      end
      x_fd = bnd;
      slot = (e / P) % 8;
      ph   = e % P;
      if (ph < G) begin
        x_an = 8'hFF; x_seg = 8'hFF;
      end else if (ph == G) begin
        up  = m_dig >> (4 * slot);
        vis = m_en[slot] && !(lz_blank && slot != 0 && up == 0);
        x_an  = vis ? ~(8'(1) << slot) : 8'hFF;
        x_seg = vis ? {~m_dp[slot], pat(up[3:0])} : 8'hFF;
      end
    end
    #1;
    chk("an", an, x_an);
    chk("seg", seg, x_seg);
    chk("frame_done", frame_done, x_fd);
  endtask

  task automatic goto(input int target);
    int n = 0;
    while (e < target && n < 20000) begin
      step();
      n++;
    end
    chk("goto_reached", e, target);
  endtask

  function automatic int next_bnd();
    return ((e / FR) + 1) * FR;
  endfunction

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    digits = d; dp_in = dp; en_in = en; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int nb;
    tbl[0]  = '{32'h76543210, 8'h00, 8'hFF, 1'b0, 0, 8'hFE, 8'hC0};
    tbl[1]  = '{32'h76543210, 8'h00, 8'hFF, 1'b0, 3, 8'hF7, 8'hB0};
    tbl[2]  = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 7, 8'hFF, 8'hFF};
    tbl[3]  = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 3, 8'hFF, 8'hFF};
    tbl[4]  = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 2, 8'hFB, 8'hB0};
    tbl[5]  = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 1, 8'hFD, 8'hC0};
    tbl[6]  = '{32'h00000305, 8'h00, 8'hFF, 1'b1, 0, 8'hFE, 8'h92};
    tbl[7]  = '{32'h0000000C, 8'h01, 8'hFF, 1'b0, 0, 8'hFE, 8'h7F};
    tbl[8]  = '{32'h76543210, 8'h00, 8'h20, 1'b0, 5, 8'hDF, 8'h92};
    tbl[9]  = '{32'h76543210, 8'h00, 8'h20, 1'b0, 4, 8'hFF, 8'hFF};
    tbl[10] = '{32'h98000000, 8'h00, 8'hFF, 1'b0, 7, 8'h7F, 8'h90};

    e = 0;
    step();
    step();
    chk("reset_an", an, 8'hFF);
    chk("reset_seg", seg, 8'hFF);
    rst = 1'b0;

    // Nothing loaded: dark display, frame_done every frame.
    goto(2 * FR + 5);
    $display("idle run done at edge %0d", e);

    foreach (tbl[i]) begin
      lz_blank = tbl[i].lz;
      do_load(tbl[i].d, tbl[i].dp, tbl[i].en);
      nb = next_bnd();
      goto(nb + tbl[i].slot * P + G);
      chk($sformatf("vec%0d_an", i), an, tbl[i].an);
      chk($sformatf("vec%0d_seg", i), seg, tbl[i].seg);
      $display("vec %0d digits %h slot %0d an %h seg %h", i, tbl[i].d, tbl[i].slot, an, seg);
    end
    lz_blank = 1'b0;

    // Mid-frame load waits for the next frame.
    do_load(32'h76543210, 8'h00, 8'hFF);
    nb = next_bnd();
    goto(nb + 3 * P + 3);
    do_load(32'h11111111, 8'h00, 8'hFF);
    goto(nb + 5 * P + G);
    chk("old_after_load", seg, 8'h92);
    goto(nb + FR + 5 * P + G);
    chk("new_next_frame", seg, 8'hF9);
    $display("midframe load: next frame seg %h", seg);

    // Load sampled on the boundary edge lands in the following frame.
    nb = next_bnd();
    goto(nb - 1);
    do_load(32'h22222222, 8'h00, 8'hFF);
    goto(nb + G);
    chk("bypass_an", an, 8'hFE);
    chk("bypass_seg", seg, 8'hA4);
    $display("boundary load: slot0 an %h seg %h", an, seg);

    // Reset mid-SHOW of digit 5 with a pending load outstanding.
    do_load(32'h33333333, 8'h00, 8'hFF);
    goto(next_bnd() - FR + 5 * P + G + 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    goto(FR + G);
    chk("pending_discarded", an, 8'hFF);
    $display("reset mid-show: an %h seg %h", an, seg);

    // Random loads, blanking toggles and digit patterns against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 19) == 0) begin
        logic [31:0] d;
        int lead;
        d = $urandom;
        lead = $urandom_range(0, 8);
        if (lead > 0) d = d & (32'hFFFFFFFF >> (4 * lead));
        digits = d; dp_in = 8'($urandom); en_in = 8'($urandom) | 8'h0F; load = 1'b1;
        $display("random load digits %h dp %h en %h at edge %0d", digits, dp_in, en_in, e + 1);
      end
      step();
      load = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SHOW_CYC, default 99984: clock cycles one digit is lit per scan slot.
REQ-002 Parameter GUARD, default 16: cycles all anodes are off between digits (anti-ghosting).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load  input  1  strobe; captures digits/dp_in/en_in into pending buffer.
REQ-006 digits  input  32  eight BCD nibbles; digits[4i+3:4i] is digit i, digit 7 is most significant.
REQ-007 dp_in  input  8  decimal point per digit, active-high.
REQ-008 en_in  input  8  digit enable per digit, active-high.
REQ-009 lz_blank  input  1  leading-zero blanking enable, sampled live.
REQ-010 an  output  8  anode selects, active-low, registered.
REQ-011 seg  output  8  segment code {dp,g..a}, active-low, registered.
REQ-012 frame_done  output  1  one-cycle pulse per completed 8-digit scan.

Function
REQ-013 FSM states: BLANK, SHOW; BLANK lasts GUARD cycles, then SHOW lasts SHOW_CYC cycles, then BLANK; digit period = GUARD+SHOW_CYC.
REQ-014 Digit index idx (3 bits) increments on each SHOW->BLANK edge; wraps 7->0.
REQ-015 In BLANK: an = 8'hFF, seg = 8'hFF.
REQ-016 In SHOW: an = ~(1<<idx) if digit idx visible, else 8'hFF; seg = {~dp[idx], decode(nibble idx)} if visible, else 8'hFF.
REQ-017 an/seg take their new values on the same edge that enters the state (zero added latency).
REQ-018 Visible = committed en[idx]=1 AND not LZ-blanked.
REQ-019 LZ-blanked (lz_blank=1 only): idx>=1, nibble idx = 0, and all nibbles above idx = 0; digit 0 is never LZ-blanked.
REQ-020 Decode: 0-9 per standard common-anode patterns (0 -> 7'b1000000, 8 -> 7'b0000000); nibble 10-15 -> 7'b1111111 (segments off); dp still applied.
REQ-021 Double buffering: load writes pending buffer and sets pend_valid; displayed (committed) data changes only at frame boundary.
REQ-022 Frame boundary = SHOW->BLANK edge with idx=7; on that edge frame_done=1 for exactly one cycle, and if pend_valid, committed <= pending, pend_valid <= 0.
REQ-023 load coincident with frame boundary: committed <= live inputs directly (bypass), pend_valid <= 0.
REQ-024 Multiple loads within one frame: last one wins.
REQ-025 load has no effect on FSM timing; scanning never stalls.

Reset
REQ-026 On rst: state BLANK, idx 0, counter 0, an 8'hFF, seg 8'hFF, frame_done 0, committed digits/dp/en all 0, pend_valid 0.
REQ-027 After rst deasserts, first SHOW (idx 0) begins GUARD cycles later; display remains dark until a load is committed (en = 0).
REQ-028 rst asserted mid-SHOW blanks outputs on the next edge and discards pending data.

Structure
REQ-029 Shared package seg_scan_pkg holds NUM_DIGITS=8, SEG_OFF=8'hFF, AN_OFF=8'hFF, FSM state encoding.
REQ-030 One combinational sub-module bcd_seg_decode (4-bit in, 7-bit active-low out, 10-15 -> all off) instantiated once on the idx-selected nibble.
REQ-031 Cycle counter width = clog2(max(SHOW_CYC,GUARD)).

Verification (SHOW_CYC=4, GUARD=2)
REQ-032 Reset release, no load -> an=8'hFF, seg=8'hFF throughout; frame_done pulses every 48 cycles.
REQ-033 load digits=32'h76543210, en=8'hFF, dp=0, wait one frame -> idx0 shows an=8'hFE, seg=8'hC0; idx3 an=8'hF7, seg=8'hB0; each digit lit exactly 4 cycles, 2-cycle dark gaps.
REQ-034 load digits=32'h00000305, lz_blank=1, en=8'hFF -> digits 7..3 dark, digit 2 seg=8'hB0, digit 1 (0 below nonzero) seg=8'hC0, digit 0 seg=8'h92.
REQ-035 digits nibble 0 = 4'hC, dp_in[0]=1 -> digit 0 seg=8'h7F.
REQ-036 load mid-frame with 32'h11111111 -> remaining digits of current frame still show old value; new value from next frame; load on boundary edge -> new value in immediately following frame.
REQ-037 rst pulsed mid-SHOW of digit 5 -> next edge an=8'hFF, seg=8'hFF, idx 0, pending load discarded.
